wrr_pkt_arbiter: RTL
====================

# wrr_pkt_arbiter

Packet-aware weighted round-robin arbiter that shares one valid/ready stream output among `NumIn` requesters. Each winner holds the output for up to `weight_i[winner]` whole packets, delimited by `last_i`, before priority rotates. Packets are never interleaved. It sits in front of shared channels (memory ports, NoC injection links) where the single-beat rotation of `rr_arb_tree` would split bursts.

## Interface
- `NumIn`, 4: number of requesters, ≥2.
- `DataWidth`, 32: payload width; unused if `DataType` is overridden.
- `DataType`, `logic [DataWidth-1:0]`: payload type.
- `WeightWidth`, 4: width of per-input packet quantum.
- `IdxWidth`, `$clog2(NumIn)`: derived, do not override.
- `idx_t`, `logic [IdxWidth-1:0]`: derived, do not override.

- `clk_i` in 1: clock, rising edge.
- `rst_ni` in 1: reset, synchronous, active-low.
- `flush_i` in 1: synchronous clear of arbitration state.
- `weight_i` in `NumIn`×`WeightWidth`: packets per quantum; 0 is treated as 1.
- `req_i` in `NumIn`: input valid.
- `last_i` in `NumIn`: final beat of packet.
- `data_i` in `NumIn`×`DataType`: input payload.
- `gnt_o` out `NumIn`: input ready.
- `req_o` out 1: output valid.
- `last_o` out 1: output last.
- `data_o` out `DataType`: output payload.
- `idx_o` out `idx_t`: source index of the current beat.
- `gnt_i` in 1: output ready.

## Operation
- Registers:
  - `state_q` ∈ {IDLE, PKT, GAP}
  - `ptr_q` (`idx_t`, highest-priority index)
  - `cur_q` (`idx_t`, locked owner)
  - `cnt_q` (`WeightWidth`, remaining packets)
- Handshake: `hs = req_o & gnt_i`. `gnt_o[i] = gnt_i & req_o & (idx_o == i)`, so `gnt_o` is one-hot or zero. Inputs obey valid/ready: `req_i` is held until granted.
- **IDLE:** winner = first `i` with `req_i[i]`, scanning `ptr_q`, `ptr_q+1`, …, wrapping at `NumIn-1`→0.
  - `req_o = |req_i`; `idx_o` = winner, or 0 if none.
  - `W = max(weight_i[winner], 1)`, sampled only here.
  - On hs without `last`: go to PKT, `cur_q`=winner, `cnt_q`=W.
  - On hs with `last` and W==1: stay IDLE, `ptr_q` = winner+1 (wrapping).
  - On hs with `last` and W>1: go to GAP, `cur_q`=winner, `cnt_q`=W-1.
- **PKT:** `idx_o=cur_q`, `req_o=req_i[cur_q]`; all other inputs are blocked.
  - On hs with `last`: if `cnt_q==1`, go to IDLE with `ptr_q=cur_q+1`; else go to GAP with `cnt_q-1`.
  - A deasserted `req_i[cur_q]` mid-packet keeps the lock (`req_o=0`, wait).
- **GAP:** `idx_o=cur_q`.
  - If `req_i[cur_q]` is set: `req_o=1`. On hs, transition as in PKT, except that a hs without `last` goes to PKT with `cnt_q` unchanged.
  - If `req_i[cur_q]` is clear: `req_o=0`, release to IDLE, `ptr_q=cur_q+1` (early quantum end).
- `data_o = data_i[idx_o]`, `last_o = last_i[idx_o]`, in every state.
- `cnt_q` decrements only on hs with `last` and never wraps below 1 in PKT/GAP.

## Timing
- Zero-latency datapath: `req_i`/`data_i`/`last_i` → `req_o`/`data_o`/`last_o` and `gnt_i` → `gnt_o` are combinational. Only state is registered.
- Arbitration decisions take effect on the clock edge after hs.
- Early release from GAP costs one bubble cycle (`req_o=0`).
- Reset (`rst_ni` low at an edge): `state_q`=IDLE, `ptr_q`=0, `cur_q`=0, `cnt_q`=0.
  - After reset with `req_i`=0: `req_o`=0, `gnt_o`=0, `idx_o`=0, `data_o=data_i[0]`, `last_o=last_i[0]`.
- `flush_i` at an edge: same reset values. Flush has priority over hs; a flushed mid-packet lock is abandoned.
- Outputs in the flush cycle itself follow the current state.
- Reset has priority over flush.
- `ptr_q` wraps from `NumIn-1` to 0. Non-power-of-two `NumIn` must never select an index ≥ `NumIn`.

## Structure
- `wrr_pkt_pkg`: `wrr_state_e` enum (IDLE=2'd0, PKT=2'd1, GAP=2'd2). `idx_t` stays local because it is parameter-dependent.
- Sub-module `wrr_rr_pick`: rotating-priority pick from `ptr_q`. It uses two `lzc` (MODE 0) on upper/lower masked requests (upper mask: `i ≥ ptr`) and outputs winner index plus empty flag.
- Assertions (non-synthesis):
  - `$onehot0(gnt_o)`.
  - `idx_o` stable while `state_q != IDLE`.
  - No hs from an input ≠ `cur_q` in PKT/GAP.

## Test plan
- Reset, then weights all 1; all 4 inputs send single-beat packets, `gnt_i`=1 → grant order 0,1,2,3,0; `ptr_q` advances each cycle.
- Input 1 sends a 3-beat packet; input 2 requests at cycle 1; `gnt_i` toggles 1,0,1,1 → the 3 beats of 1 are contiguous on `data_o`, input 2 is served only after `last`, and `gnt_o[2]`=0 throughout.
- `weight_i[0]`=3, `weight_i[1]`=1, both always sending 1-beat packets → output pattern 0,0,0,1,0,0,0,1.
- `weight_i[0]`=4, input 0 sends 1 packet then drops `req_i[0]` with input 3 pending → one bubble cycle, then 3 is served; `ptr_q`=1 before 3 wins.
- `flush_i` mid-packet of input 2 (`ptr_q`=2) with inputs 0 and 2 requesting → next cycle IDLE, `ptr_q`=0, input 0 wins.
- `weight_i[3]`=0 → treated as 1 packet; `NumIn`=3 build: `ptr_q` wraps 2→0 and `idx_o` is never 3.

Source files
------------

// File: rtl/wrr_pkt_pkg.sv
// Shared types for the packet-aware weighted round-robin arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package wrr_pkt_pkg;

    // Arbitration phase: IDLE picks a new owner, PKT is inside a packet,
    // GAP sits between packets of the same quantum.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PKT  = 2'd1,
        GAP  = 2'd2
    } wrr_state_e;

endpackage

// File: rtl/wrr_rr_pick.sv
// Rotating-priority pick: first requester at or after ptr_i, wrapping to 0.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module wrr_rr_pick #(
    parameter int unsigned NumIn    = 4,
    parameter int unsigned IdxWidth = $clog2(NumIn)
) (
    input  logic [NumIn-1:0]    req_i,
    input  logic [IdxWidth-1:0] ptr_i,
    output logic [IdxWidth-1:0] idx_o,
    output logic                empty_o
);

    logic [NumIn-1:0] upper_req;

    // Lowest set bit of a request vector (trailing-zero count).
    function automatic logic [IdxWidth-1:0] lowest_set(input logic [NumIn-1:0] v);
        lowest_set = '0;
        for (int i = NumIn - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = IdxWidth'(i);
        end
    endfunction

    // Prefer requesters at or above the pointer; otherwise wrap to the lowest one.
    always_comb begin
        upper_req = '0;
        for (int i = 0; i < NumIn; i++) begin
            upper_req[i] = req_i[i] && (IdxWidth'(i) >= ptr_i);
        end
        idx_o   = (|upper_req) ? lowest_set(upper_req) : lowest_set(req_i);
        empty_o = ~|req_i;
    end

endmodule

// File: rtl/wrr_pkt_arbiter.sv
// Packet-aware WRR arbiter: an owner keeps the output for up to weight_i whole packets.
// Latency: zero-cycle datapath; arbitration state updates on the edge after a handshake.
// Backpressure: gnt_i is forwarded combinationally to the single selected input's gnt_o.
module wrr_pkt_arbiter
    import wrr_pkt_pkg::*;
#(
    parameter int unsigned NumIn       = 4,
    parameter int unsigned DataWidth   = 32,
    parameter type         DataType    = logic [DataWidth-1:0],
    parameter int unsigned WeightWidth = 4,
    parameter int unsigned IdxWidth    = $clog2(NumIn),
    parameter type         idx_t       = logic [IdxWidth-1:0]
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              flush_i,
    input  logic [NumIn-1:0][WeightWidth-1:0] weight_i,
    input  logic [NumIn-1:0]                  req_i,
    input  logic [NumIn-1:0]                  last_i,
    input  DataType                           data_i [NumIn],
    output logic [NumIn-1:0]                  gnt_o,
    output logic                              req_o,
    output logic                              last_o,
    output DataType                           data_o,
    output idx_t                              idx_o,
    input  logic                              gnt_i
);

    wrr_state_e             state_q;
    idx_t                   ptr_q;
    idx_t                   cur_q;
    logic [WeightWidth-1:0] cnt_q;

    idx_t                   pick_idx;
    logic                   pick_empty;
    logic                   hs;
    logic                   cur_req;
    logic [WeightWidth-1:0] w_sel;
    logic [WeightWidth-1:0] w_eff;

    // Pointer increment that never leaves the 0..NumIn-1 range.
    function automatic idx_t wrap_inc(input idx_t i);
        wrap_inc = (i == idx_t'(NumIn - 1)) ? '0 : i + idx_t'(1);
    endfunction

    wrr_rr_pick #(
        .NumIn   (NumIn),
        .IdxWidth(IdxWidth)
    ) u_pick (
        .req_i  (req_i),
        .ptr_i  (ptr_q),
        .idx_o  (pick_idx),
        .empty_o(pick_empty)
    );

    // Output mux: free pick in IDLE, locked owner otherwise; zero-weight counts as one.
    always_comb begin
        cur_req = req_i[cur_q];
        w_sel   = weight_i[pick_idx];
        w_eff   = (w_sel == '0) ? WeightWidth'(1) : w_sel;
        if (state_q == IDLE) begin
            idx_o = pick_empty ? '0 : pick_idx;
            req_o = ~pick_empty;
        end else begin
            idx_o = cur_q;
            req_o = cur_req;
        end
        data_o = data_i[idx_o];
        last_o = last_i[idx_o];
        hs     = req_o & gnt_i;
        for (int i = 0; i < NumIn; i++) begin
            gnt_o[i] = hs && (idx_o == idx_t'(i));
        end
    end

    // Arbitration state: lock, count packets of the quantum, rotate the pointer on release.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            // Reset and flush clear to identical values; a flushed lock is simply dropped.
            state_q <= IDLE;
            ptr_q   <= '0;
            cur_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hs) begin
                        if (!last_o) begin
                            state_q <= PKT;
                            cur_q   <= pick_idx;
                            cnt_q   <= w_eff;
                        end else if (w_eff == WeightWidth'(1)) begin
                            ptr_q   <= wrap_inc(pick_idx);
                        end else begin
                            state_q <= GAP;
                            cur_q   <= pick_idx;
                            cnt_q   <= w_eff - WeightWidth'(1);
                        end
                    end
                end
                PKT, GAP: begin
                    if (state_q == GAP && !cur_req) begin
                        // Owner has nothing queued between packets: give up the rest of the quantum.
                        state_q <= IDLE;
                        ptr_q   <= wrap_inc(cur_q);
                    end else if (hs && last_o) begin
                        if (cnt_q == WeightWidth'(1)) begin
                            state_q <= IDLE;
                            ptr_q   <= wrap_inc(cur_q);
                        end else begin
                            state_q <= GAP;
                            cnt_q   <= cnt_q - WeightWidth'(1);
                        end
                    end else if (hs) begin
                        state_q <= PKT;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(gnt_o));

    a_idx_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q != IDLE && $past(state_q) != IDLE && !$past(flush_i)) |-> (idx_o == $past(idx_o)));

    a_owner_only: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q != IDLE) |-> (gnt_o == '0 || gnt_o[cur_q]));

endmodule
